load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 256, memory depth in 32-bit words (power of 2, 4..65536).
REQ-002 SHALL have parameter READ_LAT, default 1, cycles from request accept to response (1..8).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  unit can accept a request.
REQ-007 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned  in  1  zero-extend load result (lbu/lhu).
REQ-010 SHALL have port req_addr  in  32  byte address.
REQ-011 SHALL have port req_wdata  in  32  store data, right-justified.
REQ-012 SHALL have port rsp_valid  out  1  response present.
REQ-013 SHALL have port rsp_ready  in  1  consumer accepts response.
REQ-014 SHALL have port rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  out  1  access was misaligned, out of range or illegal size.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; accept = req_valid && req_ready.
REQ-018 SHALL, on accept, check the request; error if size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= DEPTH.
REQ-019 SHALL, on an accepted error-free store, commit the write at the accept edge using byte enables: byte lane addr[1:0]; half lanes {addr[1],0}..+1; word all four lanes; untouched bytes preserved.
REQ-020 SHALL, on an accepted error-free load, capture the addressed word at the accept edge.
REQ-021 SHALL never write memory for an erroring request.
REQ-022 SHALL go IDLE->RESP on accept when READ_LAT=1; otherwise IDLE->WAIT, with a counter moving to RESP so that rsp_valid first rises exactly READ_LAT cycles after the accept edge.
REQ-023 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_valid && rsp_ready, then return to IDLE on the same edge.
REQ-024 SHALL allow at most one outstanding request, so a load issued after a store observes the stored data.
REQ-025 SHALL select the load byte or half from the captured word by addr[1:0], then sign-extend (req_unsigned=0) or zero-extend (req_unsigned=1); word loads ignore req_unsigned.
REQ-026 SHALL respond to stores with rsp_rdata=0 and rsp_err as checked.
REQ-027 SHALL ignore req_* inputs outside IDLE.

Reset
REQ-028 SHALL, while reset=1, force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0; req_ready=1 the cycle after reset deasserts.
REQ-029 SHALL, on reset mid-operation, drop the pending response without a handshake; a store already committed stays committed.
REQ-030 SHALL NOT clear memory on reset; memory SHALL be zero at simulation start.

Structure
REQ-031 SHALL take the size encodings (SZ_B, SZ_H, SZ_W), FSM state encoding and MAX_READ_LAT from shared package lsu_pkg.
REQ-032 SHALL contain one sub-module, lsu_lane_align: combinational byte-enable and write-data replication for stores, lane select and extension for loads.

Verification
REQ-033 SHALL cover: sw 0x11223344 @0x10, then lw @0x10 -> rsp_rdata=0x11223344, rsp_err=0, rsp_valid exactly READ_LAT cycles after accept.
REQ-034 SHALL cover: sb 0xAB @0x13 over word 0x11223344, then lw @0x10 -> 0xAB223344; lb @0x13 -> 0xFFFFFFAB; lbu @0x13 -> 0x000000AB.
REQ-035 SHALL cover: sh @0x21, lw @0x22, sw @DEPTH*4 -> each rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-036 SHALL cover: READ_LAT=3 with rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0 throughout, IDLE one cycle after rsp_ready=1.
REQ-037 SHALL cover: reset asserted in WAIT -> rsp_valid never rises, req_ready=1 one cycle after reset release, earlier store data still readable.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
//   SZ_*          access size encodings carried on req_size
//   ST_*          FSM state encoding (IDLE / WAIT / RESP)
//   MAX_READ_LAT  upper bound of READ_LAT; sizes the latency counter
//   lsu_cap_t     request attributes latched at accept for the response
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int MAX_READ_LAT = 8;
    localparam int CNT_W        = $clog2(MAX_READ_LAT);

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [1:0] lo;
        logic       err;
    } lsu_cap_t;

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational lane steering.
//   Store side: st_size/st_lo/st_wdata -> st_be (byte enables) and
//               st_wdata_rep (data replicated onto every candidate lane).
//   Load side:  ld_size/ld_lo/ld_unsigned/ld_word -> ld_rdata, the selected
//               byte/half/word sign- or zero-extended to 32 bits.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_rdata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Replicating the data lets the byte enables alone pick the target lane.
    always_comb begin
        st_be        = 4'b0000;
        st_wdata_rep = st_wdata;
        case (st_size)
            SZ_B: begin
                st_be        = 4'b0001 << st_lo;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            SZ_H: begin
                st_be        = 4'b0011 << {st_lo[1], 1'b0};
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            SZ_W:    st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    always_comb begin
        ld_byte  = ld_word[{ld_lo, 3'b000} +: 8];
        ld_half  = ld_word[{ld_lo[1], 4'b0000} +: 16];
        ld_rdata = ld_word;
        case (ld_size)
            SZ_B:    ld_rdata = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_H:    ld_rdata = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_rdata = ld_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit over an internal
// word-organised memory.
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    extended load data (0 for stores/errors), error flag
// Stores commit at the accept edge; loads capture the word at the accept
// edge and respond READ_LAT cycles later.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    lsu_cap_t         cap;
    logic [31:0]      cap_word;

    logic        accept;
    logic        req_err;
    logic [AW-1:0] idx;
    logic [3:0]  st_be;
    logic [31:0] st_wdata_rep;
    logic [31:0] ld_rdata;

    assign req_ready = (state == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[AW+1:2];

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_H:    req_err = req_addr[0];
            SZ_W:    req_err = |req_addr[1:0];
            SZ_X:    req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if ({2'b00, req_addr[31:2]} >= 32'(DEPTH))
            req_err = 1'b1;
    end

    lsu_lane_align u_align (
        .st_size      (req_size),
        .st_lo        (req_addr[1:0]),
        .st_wdata     (req_wdata),
        .st_be        (st_be),
        .st_wdata_rep (st_wdata_rep),
        .ld_size      (cap.size),
        .ld_lo        (cap.lo),
        .ld_unsigned  (cap.uns),
        .ld_word      (cap_word),
        .ld_rdata     (ld_rdata)
    );

    // Memory is deliberately outside the reset domain: its contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_err) begin
            for (int b = 0; b < 4; b++)
                if (st_be[b])
                    mem[idx][8*b +: 8] <= st_wdata_rep[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cap      <= '0;
            cap_word <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cap.we   <= req_we;
                        cap.size <= req_size;
                        cap.uns  <= req_unsigned;
                        cap.lo   <= req_addr[1:0];
                        cap.err  <= req_err;
                        cap_word <= mem[idx];
                        cnt      <= '0;
                        state    <= (READ_LAT == 1) ? ST_RESP : ST_WAIT;
                    end
                end
                // Accept edge already counts as one cycle, so WAIT lasts READ_LAT-1.
                ST_WAIT: begin
                    if (cnt == CNT_W'(READ_LAT - 2))
                        state <= ST_RESP;
                    else
                        cnt <= cnt + 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == ST_RESP) && !reset;
    assign rsp_err   = rsp_valid && cap.err;
    assign rsp_rdata = (rsp_valid && !cap.we && !cap.err) ? ld_rdata : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver pushes model-predicted
// responses at each accept; a monitor pops and compares on every handshake.
module tb_load_store_unit;

    localparam int DEPTH = 64;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    load_store_unit #(.DEPTH(DEPTH), .READ_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mb [DEPTH*4];
    int          checks = 0;
    int          failures = 0;
    bit          rand_bp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: byte-addressed little-endian memory.
    function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err);
        int nb;
        logic [31:0] v;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (sz == 2'd3) || (a % nb != 0) || (longint'(a) >= longint'(DEPTH) * 4);
        rd  = '0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mb[a + i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[a + i];
                if (nb == 1)      rd = uns ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
                else if (nb == 2) rd = uns ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
                else              rd = v;
            end
        end
    endfunction

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        bit ok;
        int n;
        exp_t e;
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            fail("accept_timeout");
        end else begin
            model(we, sz, uns, a, wd, e.rdata, e.err);
            e.acc = cyc;
            q.push_back(e);
        end
        // Garbage on idle fields must be ignored.
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() > 0) fail("drain_timeout");
    endtask

    // Monitor
    initial begin
        bit          was_valid = 1'b0;
        bit          post_hs = 1'b0;
        logic [31:0] held_rd;
        logic        held_err;
        forever begin
            @(negedge clk);
            if (reset) begin
                was_valid = 1'b0;
                post_hs   = 1'b0;
                continue;
            end
            if (post_hs) begin
                chk("idle_after_handshake_ready", 32'(req_ready), 32'd1);
                post_hs = 1'b0;
            end else if (q.size() > 0) begin
                chk("busy_ready_low", 32'(req_ready), 32'd0);
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    fail("unexpected_rsp_valid");
                end else begin
                    if (!was_valid) begin
                        chk("rsp_latency", 32'(cyc - q[0].acc + 1), 32'(LAT));
                        held_rd  = rsp_rdata;
                        held_err = rsp_err;
                    end else begin
                        chk("stall_rdata_stable", rsp_rdata, held_rd);
                        chk("stall_err_stable", 32'(rsp_err), 32'(held_err));
                    end
                    was_valid = 1'b1;
                    if (rsp_ready) begin
                        chk("rsp_rdata", rsp_rdata, q[0].rdata);
                        chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
                        void'(q.pop_front());
                        was_valid = 1'b0;
                        post_hs   = 1'b1;
                    end
                end
            end else if (was_valid) begin
                fail("rsp_valid_dropped");
                was_valid = 1'b0;
            end
        end
    end

    // Random backpressure when enabled
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] a;
        for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;

        // Reset state
        repeat (3) begin
            @(negedge clk);
            chk("reset_req_ready", 32'(req_ready), 32'd0);
            chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("reset_rsp_rdata", rsp_rdata, 32'd0);
            chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Word store / load round trip
        issue(1, 2'b10, 0, 32'h10, 32'h11223344);
        issue(0, 2'b10, 0, 32'h10, 32'h0);
        // Byte merge and sign/zero extension
        issue(1, 2'b00, 0, 32'h13, 32'h000000AB);
        issue(0, 2'b10, 0, 32'h10, 32'h0);
        issue(0, 2'b00, 0, 32'h13, 32'h0);
        issue(0, 2'b00, 1, 32'h13, 32'h0);
        issue(0, 2'b01, 0, 32'h12, 32'h0);
        issue(0, 2'b01, 1, 32'h12, 32'h0);
        // Errors: misaligned half/word, out of range, illegal size
        issue(1, 2'b01, 0, 32'h21, 32'hDEADBEEF);
        issue(0, 2'b10, 0, 32'h22, 32'h0);
        issue(1, 2'b10, 0, 32'(DEPTH*4), 32'hDEADBEEF);
        issue(1, 2'b11, 0, 32'h20, 32'hDEADBEEF);
        issue(0, 2'b10, 0, 32'h20, 32'h0);
        issue(0, 2'b10, 0, 32'h0, 32'h0);
        issue(0, 2'b10, 0, 32'(DEPTH*4 - 4), 32'h0);
        drain();

        // Long stall with rsp_ready low
        rsp_ready = 1'b0;
        issue(0, 2'b10, 0, 32'h10, 32'h0);
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (!rsp_valid) fail("stall_valid_timeout");
        repeat (5) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        drain();

        // Reset while WAIT: response dropped, store survives
        issue(1, 2'b10, 0, 32'h40, 32'hCAFEF00D);
        drain();
        issue(0, 2'b10, 0, 32'h40, 32'h0);
        reset = 1'b1;
        q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("midop_reset_ready", 32'(req_ready), 32'd0);
            chk("midop_reset_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_midop_reset", 32'(req_ready), 32'd1);
        repeat (LAT + 2) begin @(posedge clk); #1; end
        issue(0, 2'b10, 0, 32'h40, 32'h0);
        drain();

        // Randomized traffic with backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) a = $urandom;
            else a = {$urandom_range(0, DEPTH + 3), 2'(0)} | 32'($urandom_range(0, 3));
            issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rand_bp = 1'b0;
        rsp_ready = 1'b1;
        drain();
        repeat (3) begin @(posedge clk); #1; end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
